// File: rtl/filter_ctrl_multi.sv
// N-channel filter pump controller: one {channel, duty} req/ack command link drives
// per-channel fill/drain FSMs with debounced floats, timeout and float-conflict faults.
module filter_ctrl_multi #(
  parameter int N_CH           = 2,
  parameter int PWM_W          = 8,
  parameter int CH_W           = 3,
  parameter int DEB_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                clk_fpga,
  input  logic                reset,
  input  logic [PWM_W-1:0]    i_dados,
  input  logic [CH_W-1:0]     i_ch,
  input  logic                i_req,
  output logic                o_ack,
  output logic                o_cmd_err,
  input  logic [N_CH-1:0]     i_boia_cheia,
  input  logic [N_CH-1:0]     i_boia_vazia,
  output logic [N_CH-1:0]     o_pwm_bomba_a,
  output logic [N_CH-1:0]     o_pwm_bomba_b,
  output logic [N_CH-1:0]     o_fault,
  output logic [3*N_CH-1:0]   o_state
);
  typedef enum logic [2:0] {
    ST_STOP = 3'd0, ST_FILLING = 3'd1, ST_DRAINING = 3'd2, ST_STOPPING = 3'd3, ST_FAULT = 3'd4
  } state_e;

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

  // Handshake: when the synchronised request is high and o_ack is low, the command is
  // captured and o_ack rises together with a one-cycle command strobe; o_ack then holds
  // until the synchronised request is seen low and falls on the following cycle.
  logic [1:0]       req_sync_q;
  logic             ack_q, cmd_vld_q, cmd_err_q;
  logic [CH_W-1:0]  cmd_ch_q;
  logic [PWM_W-1:0] cmd_duty_q;
  logic             req_s, cmd_nz;

  assign req_s  = req_sync_q[1];
  assign cmd_nz = |cmd_duty_q;

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      req_sync_q <= '0;
      ack_q      <= 1'b0;
      cmd_vld_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
      cmd_ch_q   <= '0;
      cmd_duty_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[0], i_req};
      cmd_vld_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
      if (req_s && !ack_q) begin
        ack_q      <= 1'b1;
        cmd_vld_q  <= ({1'b0, i_ch} < N_CH_L);
        cmd_err_q  <= ({1'b0, i_ch} >= N_CH_L);
        cmd_ch_q   <= i_ch;
        cmd_duty_q <= i_dados;
      end else if (!req_s && ack_q) begin
        ack_q <= 1'b0;
      end
    end
  end

  // Float bits: [N_CH-1:0] = cheia, [2*N_CH-1:N_CH] = vazia.
  logic [2*N_CH-1:0] flt_s1_q, flt_s2_q, deb_q;
  logic [DW-1:0]     deb_cnt_q [2*N_CH];

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      flt_s1_q <= '0;
      flt_s2_q <= '0;
      deb_q    <= '0;
      for (int i = 0; i < 2*N_CH; i++) deb_cnt_q[i] <= '0;
    end else begin
      flt_s1_q <= {i_boia_vazia, i_boia_cheia};
      flt_s2_q <= flt_s1_q;
      for (int i = 0; i < 2*N_CH; i++) begin
        if (flt_s2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES-1)) begin
          deb_q[i]     <= flt_s2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  logic [N_CH-1:0]  cheia_db, vazia_db, cmd_hit, active;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic [N_CH-1:0]  pwm_a_q, pwm_b_q;
  state_e           state_q [N_CH];
  state_e           state_d [N_CH];
  logic [PWM_W-1:0] duty_q  [N_CH];
  logic [PWM_W-1:0] duty_d  [N_CH];
  logic [TW-1:0]    tmo_q   [N_CH];
  logic [TW-1:0]    tmo_d   [N_CH];

  assign cheia_db = deb_q[N_CH-1:0];
  assign vazia_db = deb_q[2*N_CH-1:N_CH];

  // Priority per channel: float conflict / timeout fault, then float sensor, then command.
  always_comb begin
    cmd_hit = '0;
    active  = '0;
    for (int k = 0; k < N_CH; k++) begin
      cmd_hit[k] = cmd_vld_q && (cmd_ch_q == CH_W'(k));
      active[k]  = (state_q[k] == ST_FILLING) || (state_q[k] == ST_DRAINING) ||
                   (state_q[k] == ST_STOPPING);
      state_d[k] = state_q[k];
      duty_d[k]  = duty_q[k];
      if ((state_q[k] != ST_FAULT) && cheia_db[k] && vazia_db[k]) begin
        state_d[k] = ST_FAULT;
      end else if (active[k] && (tmo_q[k] == TW'(TIMEOUT_CYCLES-1))) begin
        state_d[k] = ST_FAULT;
      end else begin
        case (state_q[k])
          ST_STOP: if (cmd_hit[k] && cmd_nz) begin
            state_d[k] = ST_FILLING;
            duty_d[k]  = cmd_duty_q;
          end
          ST_FILLING, ST_DRAINING: begin
            if ((state_q[k] == ST_FILLING) && cheia_db[k]) state_d[k] = ST_DRAINING;
            else if ((state_q[k] == ST_DRAINING) && vazia_db[k]) state_d[k] = ST_FILLING;
            else if (cmd_hit[k] && cmd_nz) duty_d[k] = cmd_duty_q;
            else if (cmd_hit[k]) state_d[k] = ST_STOPPING;
          end
          ST_STOPPING: begin
            if (vazia_db[k]) begin
              state_d[k] = ST_STOP;
            end else if (cmd_hit[k] && cmd_nz) begin
              state_d[k] = ST_DRAINING;
              duty_d[k]  = cmd_duty_q;
            end
          end
          ST_FAULT: if (cmd_hit[k] && !cmd_nz) state_d[k] = ST_STOP;
          default: state_d[k] = ST_STOP;
        endcase
      end
      tmo_d[k] = ((state_d[k] != state_q[k]) || !active[k]) ? '0 : tmo_q[k] + TW'(1);
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      pwm_a_q   <= '0;
      pwm_b_q   <= '0;
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= ST_STOP;
        duty_q[k]  <= '0;
        tmo_q[k]   <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        duty_q[k]  <= duty_d[k];
        tmo_q[k]   <= tmo_d[k];
        // Pins follow the registered state, so A and B can never be on together.
        pwm_a_q[k] <= (state_q[k] == ST_FILLING) && (pwm_cnt_q < duty_q[k]);
        pwm_b_q[k] <= ((state_q[k] == ST_DRAINING) || (state_q[k] == ST_STOPPING)) &&
                      (pwm_cnt_q < duty_q[k]);
      end
    end
  end

  always_comb begin
    o_state = '0;
    o_fault = '0;
    for (int k = 0; k < N_CH; k++) begin
      o_state[3*k +: 3] = state_q[k];
      o_fault[k]        = (state_q[k] == ST_FAULT);
    end
  end

  assign o_ack         = ack_q;
  assign o_cmd_err     = cmd_err_q;
  assign o_pwm_bomba_a = pwm_a_q;
  assign o_pwm_bomba_b = pwm_b_q;
endmodule
